// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared definitions for the execute-stage ALU.
//   - *_CONTROL operation codes (5 bits) produced by the ALU decoder
//   - divider state encoding
//   - is_div() helper used to recognise DIV/DIVU codes
`timescale 1ns/1ps
package alu_exec_pkg;

    localparam logic [4:0] AND_CONTROL  = 5'd0;
    localparam logic [4:0] OR_CONTROL   = 5'd1;
    localparam logic [4:0] ADD_CONTROL  = 5'd2;
    localparam logic [4:0] SUB_CONTROL  = 5'd3;
    localparam logic [4:0] SLT_CONTROL  = 5'd4;
    localparam logic [4:0] NOR_CONTROL  = 5'd5;
    localparam logic [4:0] XOR_CONTROL  = 5'd6;
    localparam logic [4:0] LUI_CONTROL  = 5'd7;
    localparam logic [4:0] SLL_CONTROL  = 5'd8;
    localparam logic [4:0] SRL_CONTROL  = 5'd9;
    localparam logic [4:0] SRA_CONTROL  = 5'd10;
    localparam logic [4:0] SLLV_CONTROL = 5'd11;
    localparam logic [4:0] SRLV_CONTROL = 5'd12;
    localparam logic [4:0] SRAV_CONTROL = 5'd13;
    localparam logic [4:0] MFHI_CONTROL = 5'd14;
    localparam logic [4:0] MFLO_CONTROL = 5'd15;
    localparam logic [4:0] MTHI_CONTROL = 5'd16;
    localparam logic [4:0] MTLO_CONTROL = 5'd17;
    localparam logic [4:0] DIV_CONTROL  = 5'd18;
    localparam logic [4:0] DIVU_CONTROL = 5'd19;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    function automatic logic is_div(input logic [4:0] code);
        return (code == DIV_CONTROL) || (code == DIVU_CONTROL);
    endfunction

endpackage

// File: rtl/alu_div.sv
// alu_div: iterative restoring divider, 32-bit signed/unsigned.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          request a new divide (only honoured in IDLE)
//   signed_op      1 = DIV (signed), 0 = DIVU
//   flush          abandon any divide in progress, back to IDLE
//   a, b           dividend, divisor
//   busy           divider occupies execute this cycle (start cycle or BUSY)
//   done           final iteration completes at the coming edge; quot/rem valid
//   quot, rem      sign-corrected quotient and remainder (valid with done)
// Divide by zero yields an all-ones magnitude quotient and remainder = dividend,
// which falls out of the restoring algorithm without special casing.
`timescale 1ns/1ps
module alu_div
    import alu_exec_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        signed_op,
    input  logic        flush,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    div_state_t  state;
    logic [4:0]  cnt;
    logic [31:0] rem_r;
    logic [31:0] quo_r;
    logic [31:0] dvs_r;
    logic        neg_q;
    logic        neg_r;

    logic [32:0] partial;
    logic [33:0] trial;
    logic [31:0] next_rem;
    logic [31:0] next_quo;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    // Operand magnitudes for signed divides; -2^31 maps to 2^31 unsigned.
    always_comb begin
        a_mag = (signed_op && a[31]) ? (~a + 32'd1) : a;
        b_mag = (signed_op && b[31]) ? (~b + 32'd1) : b;
    end

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the subtraction only if it does not go negative.
    // The extra top bit of trial keeps the sign test exact for all divisors.
    always_comb begin
        partial = {rem_r, quo_r[31]};
        trial   = {1'b0, partial} - {2'b00, dvs_r};
        if (!trial[33]) begin
            next_rem = trial[31:0];
            next_quo = {quo_r[30:0], 1'b1};
        end else begin
            next_rem = partial[31:0];
            next_quo = {quo_r[30:0], 1'b0};
        end
        quot = neg_q ? (~next_quo + 32'd1) : next_quo;
        rem  = neg_r ? (~next_rem + 32'd1) : next_rem;
    end

    assign busy = ((state == DIV_IDLE) && start && !flush) || (state == DIV_BUSY);
    assign done = (state == DIV_BUSY) && (cnt == 5'd0) && !flush;

    // Divider sequencer: IDLE captures operands, BUSY runs 32 iterations
    // (counter 31 down to 0), DONE is a single cycle that lets the held
    // DIV instruction leave execute without restarting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DIV_IDLE;
            cnt   <= 5'd0;
            rem_r <= 32'd0;
            quo_r <= 32'd0;
            dvs_r <= 32'd0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (flush) begin
            state <= DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        state <= DIV_BUSY;
                        cnt   <= 5'd31;
                        rem_r <= 32'd0;
                        quo_r <= a_mag;
                        dvs_r <= b_mag;
                        neg_q <= signed_op && (a[31] ^ b[31]);
                        neg_r <= signed_op && a[31];
                    end
                end
                DIV_BUSY: begin
                    rem_r <= next_rem;
                    quo_r <= next_quo;
                    cnt   <= cnt - 5'd1;
                    if (cnt == 5'd0) begin
                        state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    state <= DIV_IDLE;
                end
                default: begin
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU of the 5-stage MIPS pipeline.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   en             execute-stage instruction valid
//   flush          cancel execute-stage instruction (and any divide)
//   alucontrol     *_CONTROL operation code
//   a, b, sa       rs operand, rt/immediate operand, shift amount
//   result, zero   combinational result and result==0
//   overflow       signed overflow of ADD/SUB (flag only)
//   stall          divider occupies execute
//   hi, lo         architectural HI/LO registers
// Build option: define ALU_DIV_EN to include the iterative divider (alu_div).
// Without it DIV/DIVU return 0, never stall and leave HI/LO untouched.
`timescale 1ns/1ps
module alu_exec
    import alu_exec_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        flush,
    input  logic [4:0]  alucontrol,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  sa,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [31:0] sum;
    logic [31:0] diff;
    logic        wr_ok;
    logic        div_done;
    logic [31:0] div_quot;
    logic [31:0] div_rem;

`ifdef ALU_DIV_EN
    logic div_start;
    logic div_busy;

    assign div_start = en && !flush && is_div(alucontrol);

    alu_div u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .signed_op (alucontrol == DIV_CONTROL),
        .flush     (flush),
        .a         (a),
        .b         (b),
        .busy      (div_busy),
        .done      (div_done),
        .quot      (div_quot),
        .rem       (div_rem)
    );

    assign stall = div_busy;
`else
    assign stall    = 1'b0;
    assign div_done = 1'b0;
    assign div_quot = 32'd0;
    assign div_rem  = 32'd0;
`endif

    assign sum   = a + b;
    assign diff  = a - b;
    assign wr_ok = en && !flush && !stall;

    // Result mux; unlisted codes (MTHI/MTLO/DIV/DIVU) produce zero.
    always_comb begin
        result   = 32'd0;
        overflow = 1'b0;
        case (alucontrol)
            ADD_CONTROL: begin
                result   = sum;
                overflow = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            SUB_CONTROL: begin
                result   = diff;
                overflow = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            AND_CONTROL:  result = a & b;
            OR_CONTROL:   result = a | b;
            XOR_CONTROL:  result = a ^ b;
            NOR_CONTROL:  result = ~(a | b);
            SLT_CONTROL:  result = {31'd0, ($signed(a) < $signed(b))};
            LUI_CONTROL:  result = {b[15:0], 16'h0000};
            SLL_CONTROL:  result = b << sa;
            SRL_CONTROL:  result = b >> sa;
            SRA_CONTROL:  result = $unsigned($signed(b) >>> sa);
            SLLV_CONTROL: result = b << a[4:0];
            SRLV_CONTROL: result = b >> a[4:0];
            SRAV_CONTROL: result = $unsigned($signed(b) >>> a[4:0]);
            MFHI_CONTROL: result = hi;
            MFLO_CONTROL: result = lo;
            default: begin
                result   = 32'd0;
                overflow = 1'b0;
            end
        endcase
    end

    assign zero = (result == 32'd0);

    // HI/LO registers. A finishing divide and an MTHI/MTLO can never collide
    // because the divide's last iteration happens while stall is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (div_done) begin
            hi <= div_rem;
            lo <= div_quot;
        end else if (wr_ok) begin
            if (alucontrol == MTHI_CONTROL) begin
                hi <= a;
            end
            if (alucontrol == MTLO_CONTROL) begin
                lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: scoreboard bench for alu_exec. The driver applies directed
// vectors and pushes hand-computed expectations; the monitor pops and compares
// them on the falling edge, when the DUT outputs for that cycle are stable.
`timescale 1ns/1ps
module tb_alu_exec;
    import alu_exec_pkg::*;

    localparam int SEL_RESULT = 0;
    localparam int SEL_ZERO   = 1;
    localparam int SEL_OVF    = 2;
    localparam int SEL_STALL  = 3;
    localparam int SEL_HI     = 4;
    localparam int SEL_LO     = 5;
    localparam int SEL_RUN    = 6;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        flush;
    logic [4:0]  alucontrol;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sa;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    chk_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cur_run      = 0;
    int   last_run     = 0;

    alu_exec dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .flush      (flush),
        .alucontrol (alucontrol),
        .a          (a),
        .b          (b),
        .sa         (sa),
        .result     (result),
        .zero       (zero),
        .overflow   (overflow),
        .stall      (stall),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Length of the most recent completed run of consecutive stall cycles.
    always @(posedge clk) begin
        if (stall) begin
            cur_run = cur_run + 1;
        end else if (cur_run != 0) begin
            last_run = cur_run;
            cur_run  = 0;
        end
    end

    // Monitor: drain every expectation queued for this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            chk_t        c;
            logic [31:0] act;
            c = sb.pop_front();
            case (c.sel)
                SEL_RESULT: act = result;
                SEL_ZERO:   act = {31'd0, zero};
                SEL_OVF:    act = {31'd0, overflow};
                SEL_STALL:  act = {31'd0, stall};
                SEL_HI:     act = hi;
                SEL_LO:     act = lo;
                default:    act = last_run;
            endcase
            tests_run = tests_run + 1;
            if (act !== c.exp) begin
                tests_failed = tests_failed + 1;
                $display("[TB] FAIL %s: got %h expected %h", c.name, act, c.exp);
            end
        end
    end

    task automatic applyStimulus(input logic e, input logic f, input logic [4:0] ctrl,
                                 input logic [31:0] av, input logic [31:0] bv,
                                 input logic [4:0] sav);
        en         = e;
        flush      = f;
        alucontrol = ctrl;
        a          = av;
        b          = bv;
        sa         = sav;
    endtask

    task automatic checkOutput(input string name, input int sel, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        sb.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold a divide instruction until stall drops (bounded); caller lands in DONE.
    task automatic runDiv(input logic [4:0] ctrl, input logic [31:0] av, input logic [31:0] bv);
        applyStimulus(1'b1, 1'b0, ctrl, av, bv, 5'd0);
        for (int i = 0; i < 40; i++) begin
            step();
            if (!stall) break;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, AND_CONTROL, 32'd0, 32'd0, 5'd0);
        #2;
        checkOutput("reset_hi", SEL_HI, 32'd0);
        checkOutput("reset_lo", SEL_LO, 32'd0);
        checkOutput("reset_stall", SEL_STALL, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        applyStimulus(1'b1, 1'b0, ADD_CONTROL, 32'h7FFFFFFF, 32'd1, 5'd0);
        checkOutput("add_ovf_result", SEL_RESULT, 32'h80000000);
        checkOutput("add_ovf_flag", SEL_OVF, 32'd1);
        checkOutput("add_ovf_zero", SEL_ZERO, 32'd0);
        step();
        applyStimulus(1'b1, 1'b0, ADD_CONTROL, 32'd3, 32'd4, 5'd0);
        checkOutput("add_plain", SEL_RESULT, 32'd7);
        checkOutput("add_plain_ovf", SEL_OVF, 32'd0);
        step();
        applyStimulus(1'b1, 1'b0, SUB_CONTROL, 32'd5, 32'd5, 5'd0);
        checkOutput("sub_eq_result", SEL_RESULT, 32'd0);
        checkOutput("sub_eq_zero", SEL_ZERO, 32'd1);
        checkOutput("sub_eq_ovf", SEL_OVF, 32'd0);
        step();
        applyStimulus(1'b1, 1'b0, SUB_CONTROL, 32'h80000000, 32'd1, 5'd0);
        checkOutput("sub_ovf_result", SEL_RESULT, 32'h7FFFFFFF);
        checkOutput("sub_ovf_flag", SEL_OVF, 32'd1);
        step();
        applyStimulus(1'b1, 1'b0, SLT_CONTROL, 32'hFFFFFFFF, 32'd1, 5'd0);
        checkOutput("slt_neg", SEL_RESULT, 32'd1);
        step();
        applyStimulus(1'b1, 1'b0, SLT_CONTROL, 32'd1, 32'hFFFFFFFF, 5'd0);
        checkOutput("slt_pos", SEL_RESULT, 32'd0);
        step();
        applyStimulus(1'b1, 1'b0, SRA_CONTROL, 32'd0, 32'h80000000, 5'd4);
        checkOutput("sra", SEL_RESULT, 32'hF8000000);
        step();
        applyStimulus(1'b1, 1'b0, SRL_CONTROL, 32'd0, 32'h80000000, 5'd4);
        checkOutput("srl", SEL_RESULT, 32'h08000000);
        step();
        applyStimulus(1'b1, 1'b0, SLL_CONTROL, 32'd0, 32'h00000003, 5'd31);
        checkOutput("sll", SEL_RESULT, 32'h80000000);
        step();
        applyStimulus(1'b1, 1'b0, SLLV_CONTROL, 32'd36, 32'd1, 5'd0);
        checkOutput("sllv_low5", SEL_RESULT, 32'h00000010);
        step();
        applyStimulus(1'b1, 1'b0, SRAV_CONTROL, 32'd8, 32'h80000000, 5'd0);
        checkOutput("srav", SEL_RESULT, 32'hFF800000);
        step();
        applyStimulus(1'b1, 1'b0, LUI_CONTROL, 32'd0, 32'h00001234, 5'd0);
        checkOutput("lui", SEL_RESULT, 32'h12340000);
        step();
        applyStimulus(1'b1, 1'b0, NOR_CONTROL, 32'd0, 32'd0, 5'd0);
        checkOutput("nor", SEL_RESULT, 32'hFFFFFFFF);
        step();
        applyStimulus(1'b1, 1'b0, XOR_CONTROL, 32'hFF00FF00, 32'h0FF00FF0, 5'd0);
        checkOutput("xor", SEL_RESULT, 32'hF0F0F0F0);
        step();
        applyStimulus(1'b1, 1'b0, AND_CONTROL, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd0);
        checkOutput("and", SEL_RESULT, 32'h7FFFFFFF);
        checkOutput("and_no_ovf", SEL_OVF, 32'd0);
        step();

        applyStimulus(1'b1, 1'b0, MTHI_CONTROL, 32'hDEAD0000, 32'd0, 5'd0);
        checkOutput("mthi_result0", SEL_RESULT, 32'd0);
        checkOutput("mthi_no_bypass", SEL_HI, 32'd0);
        step();
        applyStimulus(1'b1, 1'b0, MFHI_CONTROL, 32'd0, 32'd0, 5'd0);
        checkOutput("mfhi", SEL_RESULT, 32'hDEAD0000);
        step();
        applyStimulus(1'b1, 1'b0, MTLO_CONTROL, 32'h12345678, 32'd0, 5'd0);
        step();
        applyStimulus(1'b1, 1'b0, MFLO_CONTROL, 32'd0, 32'd0, 5'd0);
        checkOutput("mflo", SEL_RESULT, 32'h12345678);
        step();
        applyStimulus(1'b0, 1'b0, MTLO_CONTROL, 32'h0BAD0BAD, 32'd0, 5'd0);
        step();
        applyStimulus(1'b1, 1'b1, MTLO_CONTROL, 32'h0BAD0BAD, 32'd0, 5'd0);
        step();
        applyStimulus(1'b0, 1'b0, AND_CONTROL, 32'd0, 32'd0, 5'd0);
        checkOutput("mtlo_gated", SEL_LO, 32'h12345678);
        step();

`ifdef ALU_DIV_EN
        runDiv(DIV_CONTROL, 32'hFFFFFFF9, 32'd2);
        checkOutput("div_done_stall", SEL_STALL, 32'd0);
        checkOutput("div_lo", SEL_LO, 32'hFFFFFFFD);
        checkOutput("div_hi", SEL_HI, 32'hFFFFFFFF);
        step();
        applyStimulus(1'b1, 1'b0, MFLO_CONTROL, 32'd0, 32'd0, 5'd0);
        checkOutput("div_mflo", SEL_RESULT, 32'hFFFFFFFD);
        checkOutput("div_stall_len", SEL_RUN, 32'd33);
        step();

        runDiv(DIVU_CONTROL, 32'd100, 32'd0);
        checkOutput("divu0_lo", SEL_LO, 32'hFFFFFFFF);
        checkOutput("divu0_hi", SEL_HI, 32'd100);
        step();

        runDiv(DIVU_CONTROL, 32'd10, 32'd3);
        checkOutput("b2b1_stall", SEL_STALL, 32'd0);
        checkOutput("b2b1_lo", SEL_LO, 32'd3);
        checkOutput("b2b1_hi", SEL_HI, 32'd1);
        step();
        checkOutput("b2b1_len", SEL_RUN, 32'd33);
        runDiv(DIVU_CONTROL, 32'd9, 32'd3);
        checkOutput("b2b2_lo", SEL_LO, 32'd3);
        checkOutput("b2b2_hi", SEL_HI, 32'd0);
        step();
        applyStimulus(1'b0, 1'b0, AND_CONTROL, 32'd0, 32'd0, 5'd0);
        checkOutput("b2b2_len", SEL_RUN, 32'd33);
        step();

        applyStimulus(1'b1, 1'b0, DIVU_CONTROL, 32'd100, 32'd7, 5'd0);
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 5) begin
                applyStimulus(1'b1, 1'b0, MTLO_CONTROL, 32'h00000055, 32'd0, 5'd0);
                checkOutput("mtlo_stalled_stall", SEL_STALL, 32'd1);
            end
        end
        applyStimulus(1'b1, 1'b1, DIVU_CONTROL, 32'd100, 32'd7, 5'd0);
        checkOutput("flush_cycle_stall", SEL_STALL, 32'd1);
        step();
        applyStimulus(1'b0, 1'b0, AND_CONTROL, 32'd0, 32'd0, 5'd0);
        checkOutput("flush_stall_low", SEL_STALL, 32'd0);
        checkOutput("flush_hi", SEL_HI, 32'd0);
        checkOutput("flush_lo", SEL_LO, 32'd3);
        for (int i = 0; i < 30; i++) step();
        checkOutput("flush_lo_later", SEL_LO, 32'd3);
        checkOutput("flush_hi_later", SEL_HI, 32'd0);
        step();

        applyStimulus(1'b1, 1'b1, DIV_CONTROL, 32'd50, 32'd5, 5'd0);
        checkOutput("flush_start_stall", SEL_STALL, 32'd0);
        step();
        applyStimulus(1'b0, 1'b0, AND_CONTROL, 32'd0, 32'd0, 5'd0);
        checkOutput("flush_start_idle", SEL_STALL, 32'd0);
        step();

        applyStimulus(1'b1, 1'b0, DIV_CONTROL, 32'd100, 32'd7, 5'd0);
        for (int i = 0; i < 5; i++) step();
        checkOutput("mid_div_stall", SEL_STALL, 32'd1);
        step();
`else
        applyStimulus(1'b1, 1'b0, DIV_CONTROL, 32'hFFFFFFF9, 32'd2, 5'd0);
        checkOutput("nodiv_stall", SEL_STALL, 32'd0);
        checkOutput("nodiv_result", SEL_RESULT, 32'd0);
        for (int i = 0; i < 3; i++) step();
        applyStimulus(1'b1, 1'b0, DIVU_CONTROL, 32'd10, 32'd3, 5'd0);
        checkOutput("nodiv_hi", SEL_HI, 32'hDEAD0000);
        checkOutput("nodiv_lo", SEL_LO, 32'h12345678);
        checkOutput("nodiv_stall2", SEL_STALL, 32'd0);
        step();
`endif

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, AND_CONTROL, 32'd0, 32'd0, 5'd0);
        #1;
        checkOutput("rst_hi", SEL_HI, 32'd0);
        checkOutput("rst_lo", SEL_LO, 32'd0);
        checkOutput("rst_stall", SEL_STALL, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        checkOutput("post_rst_stall", SEL_STALL, 32'd0);
        step();

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            tests_run    = tests_run + 1;
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute-stage ALU of the 5-stage MIPS pipeline. It consumes the 5-bit `alucontrol` code produced by the ALU decoder and returns a combinational result for ALU and shift operations. It owns the architectural HI/LO registers. Optionally it contains an iterative signed/unsigned divider that stalls the pipeline while busy.

## Interface
Parameters: none. Width is fixed at 32 bits.

Ports:
- `clk` input 1: single pipeline clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: the execute-stage instruction is valid (not a bubble).
- `flush` input 1: cancels the execute-stage instruction, including an in-flight divide.
- `alucontrol` input 5: operation code; encodings come from the shared `*_CONTROL` defines.
- `a` input 32: rs operand.
- `b` input 32: rt or extended-immediate operand.
- `sa` input 5: shift amount field.
- `result` output 32: operation result, combinational.
- `zero` output 1: `result == 0`, used by BEQ.
- `overflow` output 1: signed overflow of ADD/SUB. The ALU only flags it; trap policy belongs elsewhere.
- `stall` output 1: high while a divide occupies execute.
- `hi`, `lo` output 32: current HI/LO register contents.

## Operation
Combinational ops set `result` as follows:
- ADD: `a+b`.
- SUB: `a-b`.
- AND, OR, XOR, NOR: bitwise on `a`, `b`.
- SLT: signed `a<b` gives 1, else 0.
- LUI: `{b[15:0],16'h0}`.
- SLL / SRL / SRA: shift `b` by `sa`. SRA is arithmetic.
- SLLV / SRLV / SRAV: shift `b` by `a[4:0]`.
- MFHI: `hi`.
- MFLO: `lo`.
- Any other code, including MTHI/MTLO/DIV/DIVU: `result=0`.

Overflow:
- `overflow` = signed overflow for ADD_CONTROL and SUB_CONTROL only.
- 0 for every other code.

HI/LO writes:
- MTHI with `en && !flush && !stall` writes `hi<=a` at the edge.
- MTLO with the same condition writes `lo<=a` at the edge.

Divider (only when the divider is compiled in; see Configuration). The state machine has three states: IDLE, BUSY, DONE.
- IDLE → BUSY when `en && !flush` and the code is DIV_CONTROL or DIVU_CONTROL. Operands are captured and the 5-bit counter is loaded with 31.
- BUSY: one restoring-division iteration per cycle; the counter decrements. The iteration at counter 0 goes to DONE and writes `lo<=quotient`, `hi<=remainder` at that edge.
- DONE → IDLE unconditionally. In DONE the held DIV instruction advances and does not restart.
- `flush` in any state → IDLE next edge. HI/LO are unchanged and the partial result is discarded.

Signed DIV rules:
- Divide magnitudes.
- Negate the quotient if the operand signs differ.
- The remainder takes the dividend's sign.

Divide by zero does not trap:
- Unsigned: quotient `32'hFFFFFFFF`, remainder = dividend.
- Signed: the magnitude result is then sign-corrected as usual.

## Timing
- `result`, `zero` and `overflow` have zero-cycle latency from the inputs.
- The combinational stall term `stall = (IDLE && div start) || BUSY`.
- `stall` is high for 33 consecutive cycles: the start cycle plus 32 BUSY cycles.
- `stall` is low in the DONE cycle; HI/LO already hold the new values in that cycle.
- MFHI/MFLO in the cycle after an MTHI/MTLO, or after DONE, see the new value. No same-cycle bypass.
- Reset values: `hi=0`, `lo=0`, state IDLE, counter 0, `stall=0`. `result`, `zero` and `overflow` follow the inputs.
- Reset asserted mid-divide forces IDLE immediately (asynchronously).
- `flush` and a divide start in the same cycle: flush wins and no divide starts.

## Configuration
Macro `ALU_DIV_EN`:
- Defined: DIV/DIVU are executed by the iterative divider as above.
- Undefined: no divider logic is built. `stall` is tied 0. DIV/DIVU give `result=0` and leave HI/LO unchanged.

## Structure
- All `*_CONTROL` encodings stay in the shared defines header included by the decoder and the ALU.
- `DIV_CONTROL` and `DIVU_CONTROL` are added there with unique 5-bit values. The decoder maps R-type funct DIV/DIVU to them.
- The divider state machine, counter and restoring datapath form the sub-module `alu_div`. It has ports `clk`, `rst_n`, `start`, `signed_op`, `flush`, `a`, `b`, `busy`, `done`, `quot`, `rem`.
- `alu_div` is instantiated only under `ALU_DIV_EN`.

## Test plan
- Combinational ops:
  - ADD `a=32'h7FFFFFFF`, `b=1` → `result=32'h80000000`, `overflow=1`.
  - SUB `a=b=5` → `result=0`, `zero=1`.
  - SLT `a=-1`, `b=1` → 1.
  - SRA `b=32'h80000000`, `sa=4` → `32'hF8000000`.
  - LUI `b=16'h1234` → `32'h12340000`.
- MTHI `a=32'hDEAD0000`, then MFHI next cycle → `result=32'hDEAD0000`. MTLO with `stall` high → `lo` unchanged.
- DIV `a=-7`, `b=2`:
  - `stall` high for exactly 33 cycles.
  - In DONE, `lo=32'hFFFFFFFD` and `hi=32'hFFFFFFFF`.
  - A following MFLO returns `32'hFFFFFFFD`.
- DIVU `a=100`, `b=0` → `lo=32'hFFFFFFFF`, `hi=100`.
- Back-to-back DIVU `10/3` then `9/3`:
  - First: `lo=3`, `hi=1`.
  - Second: `lo=3`, `hi=0`.
  - No extra restart in the DONE cycle.
- Interruptions:
  - `flush` at BUSY cycle 10 → `stall` low next cycle, HI/LO keep their prior values.
  - `rst_n` low mid-divide → `hi=lo=0` and `stall=0` immediately.
  - Build without `ALU_DIV_EN` → DIV gives `stall=0` and HI/LO unchanged.
